// File: rtl/mux_pkg.sv
// Shared select encodings and types for the behavioural 4:1 selector.
package mux_pkg;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_I0 = 2'd0;
  localparam sel_t SEL_I1 = 2'd1;
  localparam sel_t SEL_I2 = 2'd2;
  localparam sel_t SEL_I3 = 2'd3;

endpackage : mux_pkg

// File: rtl/mux4_comb.sv
// Purely combinational 4:1 data selector; unknown select drives all-X.
module mux4_comb
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  sel_t             sel,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] d
);

  // The default arm covers X/Z select in simulation and keeps the block latch-free.
  always_comb begin
    d = 'x;
    case (sel)
      SEL_I0:  d = i0;
      SEL_I1:  d = i1;
      SEL_I2:  d = i2;
      SEL_I3:  d = i3;
      default: d = 'x;
    endcase
  end

endmodule : mux4_comb

// File: rtl/mux_behavioral.sv
// 4:1 selector with combinational output, one-hot select decode and
// registered copies of output/select plus a select-change pulse.
module mux_behavioral
  import mux_pkg::*;
#(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  sel_t             sel,
  input  logic [WIDTH-1:0] i0,
  input  logic [WIDTH-1:0] i1,
  input  logic [WIDTH-1:0] i2,
  input  logic [WIDTH-1:0] i3,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] d_q,
  output sel_t             sel_q,
  output logic [3:0]       sel_onehot,
  output logic             sel_changed
);

  // No handshake: outputs are valid every cycle and the block is always ready.

  mux4_comb #(
    .WIDTH (WIDTH)
  ) u_mux4_comb (
    .sel (sel),
    .i0  (i0),
    .i1  (i1),
    .i2  (i2),
    .i3  (i3),
    .d   (d)
  );

  always_comb begin
    sel_onehot = 'x;
    case (sel)
      SEL_I0:  sel_onehot = 4'b0001;
      SEL_I1:  sel_onehot = 4'b0010;
      SEL_I2:  sel_onehot = 4'b0100;
      SEL_I3:  sel_onehot = 4'b1000;
      default: sel_onehot = 'x;
    endcase
  end

  // sel_changed compares against the previous sel_q, so it pulses the cycle after a new sel is sampled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q         <= '0;
      sel_q       <= SEL_I0;
      sel_changed <= 1'b0;
    end else begin
      d_q         <= d;
      sel_q       <= sel;
      sel_changed <= (sel != sel_q);
    end
  end

endmodule : mux_behavioral

// File: tb/tb_mux_behavioral.sv
// Directed-vector bench for mux_behavioral with an expected-queue scoreboard
// checked by an independent monitor on the falling clock edge.
module tb_mux_behavioral;

  localparam int WIDTH = 1;
  localparam int EW    = WIDTH + 4 + WIDTH + 2 + 1;
  localparam int NVEC  = 28;

  // Stimulus and hand-computed response for one clock cycle; i is {i3,i2,i1,i0}.
  typedef struct packed {
    logic       r;
    logic [1:0] s;
    logic [3:0] i;
    logic       ed;
    logic [3:0] eoh;
    logic       edq;
    logic [1:0] esq;
    logic       ech;
  } vec_t;

  logic             clk;
  logic             rst_n;
  logic [1:0]       sel;
  logic [WIDTH-1:0] i0, i1, i2, i3;
  logic [WIDTH-1:0] d, d_q;
  logic [1:0]       sel_q;
  logic [3:0]       sel_onehot;
  logic             sel_changed;

  logic [EW-1:0] exp_q[$];
  vec_t          vecs[NVEC];
  int            n_vec;
  int            n_miss;

  mux_behavioral #(
    .WIDTH (WIDTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .sel         (sel),
    .i0          (i0),
    .i1          (i1),
    .i2          (i2),
    .i3          (i3),
    .d           (d),
    .d_q         (d_q),
    .sel_q       (sel_q),
    .sel_onehot  (sel_onehot),
    .sel_changed (sel_changed)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #10 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL timeout: run exceeded 100000 ns, required completion");
    $fatal(1, "timeout");
  end

  function automatic vec_t v(input logic r, input logic [1:0] s, input logic [3:0] i,
                             input logic ed, input logic [3:0] eoh, input logic edq,
                             input logic [1:0] esq, input logic ech);
    vec_t t;
    t.r = r; t.s = s; t.i = i; t.ed = ed; t.eoh = eoh;
    t.edq = edq; t.esq = esq; t.ech = ech;
    return t;
  endfunction

  // Driver: applies a vector just after a rising edge and queues its expected response.
  task automatic drive(input vec_t t);
    @(posedge clk);
    #1;
    rst_n = t.r;
    sel   = t.s;
    i0    = WIDTH'(t.i[0]);
    i1    = WIDTH'(t.i[1]);
    i2    = WIDTH'(t.i[2]);
    i3    = WIDTH'(t.i[3]);
    exp_q.push_back({WIDTH'(t.ed), t.eoh, WIDTH'(t.edq), t.esq, t.ech});
  endtask

  // Monitor / scoreboard
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [EW-1:0] e;
      logic [EW-1:0] o;
      e = exp_q.pop_front();
      o = {d, sel_onehot, d_q, sel_q, sel_changed};
      n_vec++;
      if (o !== e) begin
        n_miss++;
        $display("FAIL vec%0d: got d=%h oh=%b d_q=%h sel_q=%0d chg=%b, required d=%h oh=%b d_q=%h sel_q=%0d chg=%b",
                 n_vec - 1, d, sel_onehot, d_q, sel_q, sel_changed,
                 e[EW-1 -: WIDTH], e[WIDTH+6 -: 4], e[WIDTH+2 -: WIDTH], e[2:1], e[0]);
      end
    end
  end

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    sel    = 2'd0;
    i0 = '0; i1 = '0; i2 = '0; i3 = '0;

    //              r  s      i3..i0   d  onehot   dq sq     chg
    vecs[0]  = v(0, 2'd0, 4'b0000, 0, 4'b0001, 0, 2'd0, 0);
    vecs[1]  = v(0, 2'd0, 4'b0000, 0, 4'b0001, 0, 2'd0, 0);
    vecs[2]  = v(0, 2'd0, 4'b0001, 1, 4'b0001, 0, 2'd0, 0);
    vecs[3]  = v(0, 2'd0, 4'b0000, 0, 4'b0001, 0, 2'd0, 0);
    vecs[4]  = v(1, 2'd0, 4'b0000, 0, 4'b0001, 0, 2'd0, 0);
    vecs[5]  = v(1, 2'd0, 4'b0001, 1, 4'b0001, 0, 2'd0, 0);
    vecs[6]  = v(1, 2'd0, 4'b0000, 0, 4'b0001, 1, 2'd0, 0);
    vecs[7]  = v(1, 2'd1, 4'b0010, 1, 4'b0010, 0, 2'd0, 0);
    vecs[8]  = v(1, 2'd1, 4'b0000, 0, 4'b0010, 1, 2'd1, 1);
    vecs[9]  = v(1, 2'd1, 4'b0010, 1, 4'b0010, 0, 2'd1, 0);
    vecs[10] = v(1, 2'd2, 4'b0100, 1, 4'b0100, 1, 2'd1, 0);
    vecs[11] = v(1, 2'd2, 4'b0000, 0, 4'b0100, 1, 2'd2, 1);
    vecs[12] = v(1, 2'd3, 4'b1000, 1, 4'b1000, 0, 2'd2, 0);
    vecs[13] = v(1, 2'd3, 4'b0000, 0, 4'b1000, 1, 2'd3, 1);
    vecs[14] = v(1, 2'd2, 4'b1011, 0, 4'b0100, 0, 2'd3, 0);
    vecs[15] = v(1, 2'd2, 4'b1111, 1, 4'b0100, 0, 2'd2, 1);
    vecs[16] = v(1, 2'd1, 4'b0000, 0, 4'b0010, 1, 2'd2, 0);
    vecs[17] = v(1, 2'd1, 4'b0000, 0, 4'b0010, 0, 2'd1, 1);
    vecs[18] = v(1, 2'd3, 4'b1000, 1, 4'b1000, 0, 2'd1, 0);
    vecs[19] = v(1, 2'd3, 4'b1000, 1, 4'b1000, 1, 2'd3, 1);
    vecs[20] = v(1, 2'd3, 4'b1000, 1, 4'b1000, 1, 2'd3, 0);
    vecs[21] = v(1, 2'd3, 4'b1000, 1, 4'b1000, 1, 2'd3, 0);
    vecs[22] = v(1, 2'd3, 4'b1111, 1, 4'b1000, 1, 2'd3, 0);
    vecs[23] = v(1, 2'd3, 4'b1111, 1, 4'b1000, 1, 2'd3, 0);
    vecs[24] = v(0, 2'd3, 4'b1111, 1, 4'b1000, 0, 2'd0, 0);
    vecs[25] = v(0, 2'd3, 4'b0111, 0, 4'b1000, 0, 2'd0, 0);
    vecs[26] = v(1, 2'd0, 4'b0000, 0, 4'b0001, 0, 2'd0, 0);
    vecs[27] = v(1, 2'd0, 4'b0000, 0, 4'b0001, 0, 2'd0, 0);

    for (int k = 0; k < NVEC; k++) drive(vecs[k]);

    repeat (2) @(posedge clk);
    if (exp_q.size() != 0) begin
      n_miss++;
      $display("FAIL drain: got %0d unchecked entries, required 0", exp_q.size());
    end
    if (n_vec != NVEC) begin
      n_miss++;
      $display("FAIL count: got %0d vectors checked, required %0d", n_vec, NVEC);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule : tb_mux_behavioral

// File: doc/mux_behavioral.md
Name: mux_behavioral

Overview:
4-to-1 selector that routes one of four data inputs to its output under a 2-bit select.
- Primary output d is purely combinational and matches a textbook behavioural 4:1 mux.
- Also provides a registered copy of the output and select, plus a select-change pulse, for downstream synchronous logic.
- Sits in datapath glue wherever a small static or slowly-changing input choice is needed.

Parameters:
- WIDTH, 1, bit width of each data input and of d/d_q.

Ports:
- clk  input  1  system clock; all registers are rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- sel  input  2  input select: 0→i0, 1→i1, 2→i2, 3→i3.
- i0  input  WIDTH  data input 0.
- i1  input  WIDTH  data input 1.
- i2  input  WIDTH  data input 2.
- i3  input  WIDTH  data input 3.
- d  output  WIDTH  combinational selected data.
- d_q  output  WIDTH  d registered one clock later.
- sel_q  output  2  sel registered one clock later.
- sel_onehot  output  4  combinational one-hot decode of sel (bit n set when sel==n).
- sel_changed  output  1  one-cycle pulse, registered, when sel differs from sel_q.

Behaviour:
- d = i0/i1/i2/i3 for sel = 0/1/2/3.
  - d is zero-latency and independent of clk and rst_n; it responds to sel or any data change in the same delta.
  - If sel contains X/Z, d is driven all-X (default branch). No latch is inferred.
- sel_onehot: exactly one bit set for any known sel; all-X for unknown sel.
- Registers (d_q, sel_q, sel_changed):
  - rst_n low asynchronously forces d_q=0, sel_q=2'b00, sel_changed=0.
  - While rst_n is low, the registers hold these values regardless of clk.
  - After rst_n deasserts, the first rising clk edge loads normally.
- On each rising edge with rst_n high:
  - d_q <= d.
  - sel_q <= sel.
  - sel_changed <= (sel != sel_q).
- Latency: d 0 cycles; d_q and sel_q 1 cycle; sel_changed is asserted the cycle after the edge that samples a new sel.
- sel_changed and data change on the same edge: d_q captures the newly selected input, and sel_changed pulses.
- A data change on an unselected input affects neither d nor d_q.
- Reset mid-operation: d keeps tracking inputs; registered outputs clear immediately (asynchronously).
- Outputs have no handshake; the block is always ready.

Decomposition:
- Shared package mux_pkg:
  - localparams SEL_I0=2'd0, SEL_I1=2'd1, SEL_I2=2'd2, SEL_I3=2'd3.
  - typedef sel_t as logic [1:0].
- One natural sub-module: mux4_comb (parameter WIDTH; ports sel, i0..i3, d), pure combinational case statement.
- mux_behavioral instantiates mux4_comb and adds the onehot decode and the output registers.

Test Plan:
- Reset: hold rst_n=0 for 100 ns, all inputs 0, sel=0 → d=0, d_q=0, sel_q=0, sel_changed=0; d still follows inputs during reset.
- sel=0, i0 toggles 0→1→0 at 50 ns spacing, others 0 → d follows i0 (0,1,0) immediately; d_q follows one clock later; sel_onehot=4'b0001.
- Repeat for sel=1, 2, 3, toggling only the selected input → d follows i1, i2, i3 respectively; sel_onehot=0010, 0100, 1000.
- Isolation: sel=2, i0=i1=i3=1, i2=0 → d=0; then set i2=1 → d=1.
- sel step 1→3 → sel_changed=1 for exactly one cycle after the sampling edge; sel_q=3 thereafter; a constant sel keeps sel_changed=0.
- Async reset mid-run: rst_n pulled low between clock edges with d_q=1 → d_q=0 and sel_q=0 immediately, without waiting for a clock edge.
